// File: rtl/sm_fixed_pkg.sv
// Shared types and constants for the sign-magnitude Q15.8 arithmetic unit.
package sm_fixed_pkg;

  localparam int SM_W      = 24;
  localparam int SM_FRAC_W = 8;

  typedef struct packed {
    logic              sign;
    logic [SM_W-2:0]   mag;
  } sm_word_t;

  typedef enum logic {
    SM_ADD = 1'b0,
    SM_MUL = 1'b1
  } sm_op_e;

  localparam logic [SM_W-1:0] SM_ONE     = SM_W'(1) << SM_FRAC_W;
  localparam logic [SM_W-2:0] SM_MAX_MAG = {(SM_W-1){1'b1}};

endpackage

// File: rtl/sm_fixed_arith_if.sv
// Operand/result bundle of the sign-magnitude arithmetic unit.
interface sm_fixed_arith_if
  import sm_fixed_pkg::*;
#(
  parameter int W = SM_W
) ();

  logic          in_valid;
  sm_op_e        op;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          out_valid;
  logic [W-1:0]  result;
  logic          overflow;

  modport master (
    output in_valid, op, a, b,
    input  out_valid, result, overflow
  );

  modport slave (
    input  in_valid, op, a, b,
    output out_valid, result, overflow
  );

endinterface

// File: rtl/sm_fixed_core.sv
// Combinational sign-magnitude add/multiply with zero normalization.
// Build option SM_ARITH_SAT_EN: saturate the magnitude on overflow instead of wrapping.
module sm_fixed_core
  import sm_fixed_pkg::*;
#(
  parameter int W      = SM_W,
  parameter int FRAC_W = SM_FRAC_W
) (
  input  sm_op_e        op,
  input  logic [W-1:0]  a,
  input  logic [W-1:0]  b,
  output logic [W-1:0]  result,
  output logic          overflow
);

  localparam int MW = W - 1;
  localparam int PW = 2 * MW;

  logic [MW-1:0] ma, mb;
  logic          sa, sb;
  logic [MW:0]   sum;
  logic [PW-1:0] prod;
  logic [PW-1:0] prod_sh;
  logic [MW-1:0] mag;
  logic          sign;
  logic          ovf;

  assign ma = a[MW-1:0];
  assign mb = b[MW-1:0];
  // Negative zero behaves as positive zero in sign comparisons.
  assign sa = a[W-1] & (|ma);
  assign sb = b[W-1] & (|mb);

  assign sum     = {1'b0, ma} + {1'b0, mb};
  assign prod    = {{MW{1'b0}}, ma} * {{MW{1'b0}}, mb};
  assign prod_sh = prod >> FRAC_W;

  always_comb begin
    sign = 1'b0;
    mag  = '0;
    ovf  = 1'b0;
    if (op == SM_ADD) begin
      if (sa == sb) begin
        mag  = sum[MW-1:0];
        ovf  = sum[MW];
        sign = sa;
      end else if (ma >= mb) begin
        mag  = ma - mb;
        sign = sa;
      end else begin
        mag  = mb - ma;
        sign = sb;
      end
    end else begin
      mag  = prod_sh[MW-1:0];
      ovf  = |prod_sh[PW-1:MW];
      sign = sa ^ sb;
    end
`ifdef SM_ARITH_SAT_EN
    if (ovf) begin
      mag = '1;
    end
`endif
    if (mag == '0) begin
      sign = 1'b0;
    end
  end

  assign result   = {sign, mag};
  assign overflow = ovf;

endmodule

// File: rtl/sm_fixed_arith.sv
// Registered sign-magnitude Q15.8 add/multiply unit, one result per cycle, latency 1.
// Build option SM_ARITH_SAT_EN selects saturation on overflow (see sm_fixed_core).
module sm_fixed_arith
  import sm_fixed_pkg::*;
#(
  parameter int W      = SM_W,
  parameter int FRAC_W = SM_FRAC_W
) (
  input  logic             clk,
  input  logic             rst_n,
  sm_fixed_arith_if.slave  bus
);

  logic [W-1:0] core_result;
  logic         core_overflow;

  sm_fixed_core #(
    .W      (W),
    .FRAC_W (FRAC_W)
  ) u_core (
    .op       (bus.op),
    .a        (bus.a),
    .b        (bus.b),
    .result   (core_result),
    .overflow (core_overflow)
  );

  // result/overflow keep the last accepted value while in_valid is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out_valid <= 1'b0;
      bus.result    <= '0;
      bus.overflow  <= 1'b0;
    end else begin
      bus.out_valid <= bus.in_valid;
      if (bus.in_valid) begin
        bus.result   <= core_result;
        bus.overflow <= core_overflow;
      end
    end
  end

endmodule

// File: tb/tb_sm_fixed_arith.sv
// Scoreboard bench for sm_fixed_arith: directed cases plus random traffic against a value-level model.
module tb_sm_fixed_arith;
  import sm_fixed_pkg::*;

  localparam int W  = SM_W;
  localparam int MW = W - 1;
  localparam longint LIM = longint'(1) << MW;

`ifdef SM_ARITH_SAT_EN
  localparam logic [W-1:0] OV_ADD = 24'h7FFFFF;
  localparam logic [W-1:0] OV_MUL = 24'hFFFFFF;
`else
  localparam logic [W-1:0] OV_ADD = 24'h000000;
  localparam logic [W-1:0] OV_MUL = 24'h000000;
`endif

  typedef struct {
    logic [W-1:0] res;
    logic         ovf;
    int           due;
  } exp_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   n_checks;
  int   n_fail;
  bit   mon_en;
  exp_t q[$];
  logic [W-1:0] last_res;
  logic         last_ovf;

  sm_fixed_arith_if #(.W(W)) bus ();

  sm_fixed_arith dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, req);
    end
  endtask

  // Works on signed real values: value = +/- mag / 2^FRAC, product rescaled by 2^FRAC.
  function automatic void model(input logic o, input logic [W-1:0] x, input logic [W-1:0] y,
                                output logic [W-1:0] r, output logic ov);
    longint vx, vy, v, m;
    bit     neg;
    vx = x[W-1] ? -longint'(x[MW-1:0]) : longint'(x[MW-1:0]);
    vy = y[W-1] ? -longint'(y[MW-1:0]) : longint'(y[MW-1:0]);
    v  = o ? vx * vy : vx + vy;
    neg = (v < 0);
    m   = neg ? -v : v;
    if (o) m = m / (longint'(1) << SM_FRAC_W);
    ov = (m >= LIM);
`ifdef SM_ARITH_SAT_EN
    if (ov) m = LIM - 1;
`else
    m = m % LIM;
`endif
    if (m == 0) neg = 1'b0;
    r = {neg, m[MW-1:0]};
  endfunction

  task automatic drive(input logic v, input logic o, input logic [W-1:0] x, input logic [W-1:0] y,
                       input bit use_model, input logic [W-1:0] er, input logic eo);
    logic [W-1:0] r;
    logic         ov;
    @(negedge clk);
    bus.in_valid = v;
    bus.op       = sm_op_e'(o);
    bus.a        = x;
    bus.b        = y;
    if (v) begin
      if (use_model) model(o, x, y, r, ov);
      else begin
        r  = er;
        ov = eo;
      end
      q.push_back('{res: r, ovf: ov, due: cyc + 1});
    end
  endtask

  task automatic issue_dir(input logic o, input logic [W-1:0] x, input logic [W-1:0] y,
                           input logic [W-1:0] er, input logic eo);
    drive(1'b1, o, x, y, 1'b0, er, eo);
  endtask

  function automatic logic [W-1:0] rnd_operand();
    logic [MW-1:0] m;
    m = MW'($urandom);
    case ($urandom_range(0, 3))
      0: m = m & 23'h000FFF;
      1: m = m & 23'h03FFFF;
      2: ;
      default: m = $urandom_range(0, 1) ? '0 : '1;
    endcase
    return {1'($urandom_range(0, 1)), m};
  endfunction

  task automatic issue_rnd(input logic v);
    drive(v, 1'($urandom_range(0, 1)), rnd_operand(), rnd_operand(), 1'b1, '0, 1'b0);
  endtask

  always @(negedge clk) begin
    if (mon_en && rst_n) begin
      exp_t e;
      bit   exp_v;
      exp_v = 1'b0;
      if (q.size() > 0 && q[0].due <= cyc) begin
        e = q.pop_front();
        exp_v = (e.due == cyc);
      end
      check("out_valid", 32'(bus.out_valid), 32'(exp_v));
      if (exp_v) begin
        check("result", 32'(bus.result), 32'(e.res));
        check("overflow", 32'(bus.overflow), 32'(e.ovf));
        last_res = e.res;
        last_ovf = e.ovf;
      end else begin
        check("hold_result", 32'(bus.result), 32'(last_res));
        check("hold_overflow", 32'(bus.overflow), 32'(last_ovf));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got running, expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    sm_word_t sub_b;
    n_checks = 0;
    n_fail   = 0;
    mon_en   = 1'b0;
    last_res = '0;
    last_ovf = 1'b0;
    rst_n    = 1'b0;
    bus.in_valid = 1'b0;
    bus.op       = SM_ADD;
    bus.a        = '0;
    bus.b        = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_out_valid", 32'(bus.out_valid), 32'd0);
    check("reset_result", 32'(bus.result), 32'd0);
    check("reset_overflow", 32'(bus.overflow), 32'd0);
    @(negedge clk);
    rst_n  = 1'b1;
    mon_en = 1'b1;
    drive(1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b0);

    issue_dir(1'b0, 24'h000300, 24'h800100, 24'h000200, 1'b0);
    drive(1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b0);
    issue_dir(1'b1, 24'h000200, 24'h800180, 24'h800300, 1'b0);
    issue_dir(1'b0, SM_ONE, 24'h800100, 24'h000000, 1'b0);
    issue_dir(1'b1, 24'h000080, 24'h000001, 24'h000000, 1'b0);
    issue_dir(1'b1, 24'h800000, 24'h000500, 24'h000000, 1'b0);
    issue_dir(1'b0, 24'h7FFF00, 24'h000100, OV_ADD, 1'b1);
    issue_dir(1'b1, 24'h400000, 24'h800200, OV_MUL, 1'b1);
    sub_b = '{sign: 1'b1, mag: {15'd5, 8'h00}};
    issue_dir(1'b0, 24'h000300, sub_b, 24'h800200, 1'b0);
    issue_dir(1'b0, 24'h800000, 24'h800005, 24'h800005, 1'b0);
    issue_dir(1'b0, 24'h000000, {1'b0, SM_MAX_MAG}, 24'h7FFFFF, 1'b0);
    repeat (2) drive(1'b0, 1'b1, 24'h123456, 24'h654321, 1'b0, '0, 1'b0);

    for (int i = 0; i < 10; i++) issue_rnd(1'b1);
    repeat (2) drive(1'b0, 1'b0, 24'h0F0F0F, 24'h00FF00, 1'b0, '0, 1'b0);
    for (int i = 0; i < 300; i++) issue_rnd($urandom_range(0, 3) != 0);

    issue_rnd(1'b1);
    @(posedge clk);
    #1;
    check("pre_reset_out_valid", 32'(bus.out_valid), 32'd1);
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("async_reset_out_valid", 32'(bus.out_valid), 32'd0);
    check("async_reset_result", 32'(bus.result), 32'd0);
    check("async_reset_overflow", 32'(bus.overflow), 32'd0);
    q.delete();
    last_res = '0;
    last_ovf = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    issue_dir(1'b1, 24'h000200, 24'h800180, 24'h800300, 1'b0);
    for (int i = 0; i < 20; i++) issue_rnd(1'b1);

    repeat (4) drive(1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b0);
    check("scoreboard_drained", 32'(q.size()), 32'd0);
    mon_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
